// File: rtl/mic1_mem_arbiter_pkg.sv
// mic1_pkg: shared types and helpers for the mic1 memory arbiter.
// Holds the arbiter state encoding, the memory_ctrl bit positions and
// the instruction byte-lane selector used by the arbiter and fetch buffer.
package mic1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Bit positions of the mic1 memory_ctrl field
  localparam int MEMCTL_FETCH = 0;
  localparam int MEMCTL_READ  = 1;
  localparam int MEMCTL_WRITE = 2;

  // Pick the instruction byte out of a memory word for a given byte lane
  function automatic logic [7:0] sel_lane(input logic [31:0] word,
                                          input logic [1:0]  lane,
                                          input logic        big_end);
    logic [1:0]  l;
    logic [31:0] sh;
    l  = big_end ? (2'd3 - lane) : lane;
    sh = word >> {l, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/mic1_mem_arbiter_if.sv
// mic1_mem_arbiter_if: core-side and memory-side bus of the mic1 memory arbiter.
// slave  = the arbiter's view; master = the environment (core + memory) view.
interface mic1_mem_arbiter_if;
  logic        core_read;
  logic        core_write;
  logic        core_fetch;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_pc;
  logic [31:0] core_rdata;
  logic [7:0]  core_instr;
  logic        core_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  core_read, core_write, core_fetch, core_addr, core_wdata, core_pc,
    input  mem_rdata, mem_ready,
    output core_rdata, core_instr, core_stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_read, core_write, core_fetch, core_addr, core_wdata, core_pc,
    output mem_rdata, mem_ready,
    input  core_rdata, core_instr, core_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mic1_mem_arbiter_fetch_buffer.sv
// mic1_fetch_buffer: one-word instruction buffer (tag = word address, valid bit).
// Only instantiated when MIC1_ARB_FETCH_BUF_EN is defined.
module mic1_fetch_buffer
  import mic1_pkg::*;
#(
  parameter bit BIG_END = 1'b0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] lookup_pc_i,
  output logic        hit_o,
  output logic [7:0]  instr_o,
  input  logic        fill_i,
  input  logic [29:0] fill_tag_i,
  input  logic [31:0] fill_word_i,
  input  logic        inval_i,
  input  logic [29:0] inval_addr_i
);

  logic        valid_q;
  logic [29:0] tag_q;
  logic [31:0] word_q;

  // Fill on a completed fetch; drop the entry when its word is written
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      tag_q   <= 30'd0;
      word_q  <= 32'd0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      word_q  <= fill_word_i;
    end else if (inval_i && (inval_addr_i == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

  assign hit_o   = valid_q & (tag_q == lookup_pc_i[31:2]);
  assign instr_o = sel_lane(word_q, lookup_pc_i[1:0], BIG_END);

endmodule

// File: rtl/mic1_mem_arbiter.sv
// mic1_mem_arbiter: shares one variable-latency memory between the mic1 data
// port (MAR/MDR) and fetch port (PC/MBR), data access always first.
// Optional feature macro: MIC1_ARB_FETCH_BUF_EN (one-word fetch buffer).
module mic1_mem_arbiter
  import mic1_pkg::*;
#(
  parameter int TIMEOUT       = 255,
  parameter bit FETCH_BIG_END = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  mic1_mem_arbiter_if.slave   bus,
  output logic                err
);

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  arb_state_t  state_q, state_d;
  logic        rd_q, fe_q;
  logic [31:0] pc_q;
  logic [31:0] cnt_q;
  logic        mem_req_q, mem_we_q, err_q;
  logic [31:0] mem_addr_q, mem_wdata_q, core_rdata_q;
  logic [7:0]  core_instr_q;
  logic        core_stall_s;
  logic [2:0]  req_vec_s;
  logic        any_req_s, data_req_s, tmo_s, acc_done_s;
  logic        fb_hit_s;
  logic [7:0]  fb_instr_s;
  logic        unused_s;

  assign req_vec_s[MEMCTL_FETCH] = bus.core_fetch;
  assign req_vec_s[MEMCTL_READ]  = bus.core_read;
  assign req_vec_s[MEMCTL_WRITE] = bus.core_write;
  assign any_req_s  = |req_vec_s;
  assign data_req_s = req_vec_s[MEMCTL_READ] | req_vec_s[MEMCTL_WRITE];
  assign tmo_s      = TMO_EN & mem_req_q & ~bus.mem_ready & (cnt_q == TMO_LAST);
  assign acc_done_s = mem_req_q & (bus.mem_ready | tmo_s);
  assign unused_s   = ^bus.core_addr[31:30];

`ifdef MIC1_ARB_FETCH_BUF_EN
  mic1_fetch_buffer #(.BIG_END(FETCH_BIG_END)) u_fetch_buffer (
    .clk_i        (clk),
    .reset_i      (reset),
    .lookup_pc_i  (bus.core_pc),
    .hit_o        (fb_hit_s),
    .instr_o      (fb_instr_s),
    .fill_i       ((state_q == FETCH) & mem_req_q & bus.mem_ready),
    .fill_tag_i   (pc_q[31:2]),
    .fill_word_i  (bus.mem_rdata),
    .inval_i      ((state_q == IDLE) & bus.core_write),
    .inval_addr_i (bus.core_addr[29:0])
  );
`else
  assign fb_hit_s   = 1'b0;
  assign fb_instr_s = 8'h00;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: serialise data access before fetch, hold DONE until run
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!any_req_s)     state_d = IDLE;
        else if (data_req_s) state_d = DATA;
        else if (fb_hit_s)  state_d = DONE;
        else                state_d = FETCH;
      end
      DATA: begin
        if (acc_done_s) state_d = fe_q ? FETCH : DONE;
        else            state_d = DATA;
      end
      FETCH: begin
        if (acc_done_s) state_d = DONE;
        else            state_d = FETCH;
      end
      DONE: begin
        if (run) state_d = IDLE;
        else     state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM output: freeze the core until results are ready and run is high
  always_comb begin
    core_stall_s = 1'b0;
    case (state_q)
      IDLE:    core_stall_s = any_req_s;
      DATA:    core_stall_s = 1'b1;
      FETCH:   core_stall_s = 1'b1;
      DONE:    core_stall_s = ~run;
      default: core_stall_s = 1'b0;
    endcase
  end

  // Request latching, memory bus registers, timeout counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= 1'b0; fe_q <= 1'b0; pc_q <= 32'd0; cnt_q <= 32'd0;
      mem_req_q <= 1'b0; mem_we_q <= 1'b0; err_q <= 1'b0;
      mem_addr_q <= 32'd0; mem_wdata_q <= 32'd0;
      core_rdata_q <= 32'd0; core_instr_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_s) begin
            // write wins over a simultaneous read; the read result is dropped
            rd_q  <= req_vec_s[MEMCTL_READ] & ~req_vec_s[MEMCTL_WRITE];
            fe_q  <= req_vec_s[MEMCTL_FETCH];
            pc_q  <= bus.core_pc;
            cnt_q <= 32'd0;
            if (req_vec_s[MEMCTL_READ] && req_vec_s[MEMCTL_WRITE]) err_q <= 1'b1;
            if (data_req_s) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_vec_s[MEMCTL_WRITE];
              mem_addr_q  <= {bus.core_addr[29:0], 2'b00};
              mem_wdata_q <= bus.core_wdata;
            end else if (fb_hit_s) begin
              core_instr_q <= fb_instr_s;
            end else begin
              mem_req_q  <= 1'b1;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {bus.core_pc[31:2], 2'b00};
            end
          end
        end
        DATA: begin
          if (acc_done_s) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (rd_q)  core_rdata_q <= tmo_s ? 32'd0 : bus.mem_rdata;
            if (tmo_s) err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        FETCH: begin
          if (!mem_req_q) begin
            // reissue after the idle gap that follows a data access
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {pc_q[31:2], 2'b00};
            cnt_q      <= 32'd0;
          end else if (acc_done_s) begin
            mem_req_q    <= 1'b0;
            core_instr_q <= tmo_s ? 8'h00 : sel_lane(bus.mem_rdata, pc_q[1:0], FETCH_BIG_END);
            if (tmo_s) err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        DONE: begin
          mem_req_q <= 1'b0;
        end
        default: begin
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_stall = core_stall_s;
  assign bus.core_rdata = core_rdata_q;
  assign bus.core_instr = core_instr_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// Testbench for mic1_mem_arbiter (TIMEOUT=4, little-endian fetch lanes).
module tb_mic1_mem_arbiter;

  localparam int TMO = 4;
  localparam bit BIG = 1'b0;

  logic clk;
  logic reset;
  logic run;
  logic err;

  mic1_mem_arbiter_if bus();

  mic1_mem_arbiter #(.TIMEOUT(TMO), .FETCH_BIG_END(BIG)) dut (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .bus   (bus),
    .err   (err)
  );

  int checks = 0;
  int errors = 0;

  // memory seen by the DUT, and the bench's own expected memory image
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  int lat = 0;
  int acc_cnt = 0;
  int req_hi = 0;
  int wcnt = 0;
  bit prev_req = 1'b0;

  // reference model state
  logic [31:0] m_rdata;
  logic [7:0]  m_instr;
  bit          m_err;
  bit          b_valid;
  logic [29:0] b_tag;

  typedef struct {
    bit r; bit w; bit f;
    logic [31:0] a; logic [31:0] wd; logic [31:0] pc;
    int l;
    logic [31:0] e_rdata; logic [7:0] e_instr; int e_stall; int e_acc;
  } vec_t;
  vec_t tbl [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory responder: ready after 'lat' wait cycles of an active request
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (!prev_req) begin
          acc_cnt++;
          wcnt = 0;
        end
        req_hi++;
        if (wcnt >= lat) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            bus.mem_rdata = 32'd0;
          end else begin
            bus.mem_rdata = mem[bus.mem_addr[9:2]];
          end
        end else begin
          bus.mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        bus.mem_ready = 1'b0;
      end
      prev_req = bus.mem_req;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lane_of(input logic [31:0] word, input logic [1:0] pcl);
    int k;
    k = BIG ? (3 - int'(pcl)) : int'(pcl);
    return word[8*k +: 8];
  endfunction

  // Spec-level model of one transaction: updates expected state, returns stall cycles and accesses
  task automatic model(input bit r, input bit w, input bit f, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pc, input int l,
                       output int st, output int ac);
    bit data;
    bit hit;
    data = r | w;
    hit  = 1'b0;
`ifdef MIC1_ARB_FETCH_BUF_EN
    hit = f && !data && b_valid && (b_tag == pc[31:2]);
`endif
    if (r && w) m_err = 1'b1;
    if (w) begin
      ref_mem[a[7:0]] = wd;
      if (b_valid && (b_tag == a[29:0])) b_valid = 1'b0;
    end else if (r) begin
      m_rdata = ref_mem[a[7:0]];
    end
    if (f) begin
      m_instr = lane_of(ref_mem[pc[9:2]], pc[1:0]);
      if (!hit) begin
        b_valid = 1'b1;
        b_tag   = pc[31:2];
      end
    end
    if (hit) st = 1;
    else     st = 1 + (data ? l + 1 : 0) + (f ? (data ? 1 : 0) + l + 1 : 0);
    ac = (data ? 1 : 0) + ((f && !hit) ? 1 : 0);
  endtask

  // Issue one request with run=1 and count stall cycles until the core is released
  task automatic run_txn(input bit r, input bit w, input bit f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] pc, input int l,
                         output int st, output int ac);
    int a0;
    @(negedge clk);
    lat = l;
    bus.core_read = r; bus.core_write = w; bus.core_fetch = f;
    bus.core_addr = a; bus.core_wdata = wd; bus.core_pc = pc;
    run = 1'b1;
    a0 = acc_cnt;
    #1;
    st = 0;
    for (int i = 0; i < 60; i++) begin
      if (!bus.core_stall) break;
      st++;
      @(negedge clk);
      #1;
    end
    ac = acc_cnt - a0;
  endtask

  task automatic drop_req();
    bus.core_read = 1'b0; bus.core_write = 1'b0; bus.core_fetch = 1'b0;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_rdata = 32'd0; m_instr = 8'h00; m_err = 1'b0; b_valid = 1'b0; b_tag = 30'd0;
  endtask

  initial begin
    int st, ac, mst, mac;
    logic [31:0] ra, rwd, rpc;
    int k, rl, hold;

    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      mem[i] = {b, ~b, b ^ 8'h5A, 8'hC3};
    end
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h40] = 32'h44332211;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    model_reset();

    //        r     w     f     addr        wdata          pc          lat rdata          instr  stall acc
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,         32'h0,      0, 32'hDEADBEEF, 8'h00, 2, 1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'h0,         32'h103,    0, 32'hDEADBEEF, 8'h44, 4, 2};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h40, 32'hAABBCCDD, 32'h100,    0, 32'hDEADBEEF, 8'hDD, 4, 2};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h0,         32'h41,     2, 32'hDEADBEEF, 8'hBE, 4, 1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0,         32'h0,      1, 32'hAABBCCDD, 8'hBE, 3, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 32'h0,      3, 32'hAABBCCDD, 8'hBE, 5, 1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h0,         32'h0,      0, 32'h12345678, 8'hBE, 2, 1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h0,         32'h82,     0, 32'h12345678, 8'h34, 2, 1};

    // reset state
    reset = 1'b1; run = 1'b1;
    bus.core_read = 1'b0; bus.core_write = 1'b0; bus.core_fetch = 1'b0;
    bus.core_addr = 32'd0; bus.core_wdata = 32'd0; bus.core_pc = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rdata", bus.core_rdata, 32'd0);
    chk("rst_instr", 32'(bus.core_instr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(bus.core_stall), 32'd0);

    // directed vectors
    for (int v = 0; v < 8; v++) begin
      run_txn(tbl[v].r, tbl[v].w, tbl[v].f, tbl[v].a, tbl[v].wd, tbl[v].pc, tbl[v].l, st, ac);
      model(tbl[v].r, tbl[v].w, tbl[v].f, tbl[v].a, tbl[v].wd, tbl[v].pc, tbl[v].l, mst, mac);
      chk($sformatf("vec%0d_rdata", v), bus.core_rdata, tbl[v].e_rdata);
      chk($sformatf("vec%0d_instr", v), 32'(bus.core_instr), 32'(tbl[v].e_instr));
      chk($sformatf("vec%0d_stall", v), 32'(st), 32'(tbl[v].e_stall));
      chk($sformatf("vec%0d_acc", v), 32'(ac), 32'(tbl[v].e_acc));
      chk($sformatf("vec%0d_err", v), 32'(err), 32'd0);
      drop_req();
    end
    chk("mem_after_write", mem[8'h40], 32'hAABBCCDD);

    // randomized transactions against the model
    for (int n = 0; n < 40; n++) begin
      do k = $urandom_range(1, 7); while (k == 3 || k == 7);
      ra  = 32'($urandom_range(0, 15));
      rwd = $urandom;
      rpc = 32'($urandom_range(0, 63));
      rl  = $urandom_range(0, 3);
      run_txn(k[1], k[2], k[0], ra, rwd, rpc, rl, st, ac);
      model(k[1], k[2], k[0], ra, rwd, rpc, rl, mst, mac);
      chk($sformatf("rnd%0d_rdata", n), bus.core_rdata, m_rdata);
      chk($sformatf("rnd%0d_instr", n), 32'(bus.core_instr), 32'(m_instr));
      chk($sformatf("rnd%0d_stall", n), 32'(st), 32'(mst));
      chk($sformatf("rnd%0d_acc", n), 32'(ac), 32'(mac));
      chk($sformatf("rnd%0d_err", n), 32'(err), 32'(m_err));
      drop_req();
    end

    // read and write together: write wins, err set
    run_txn(1'b1, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0, 0, st, ac);
    model(1'b1, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0, 0, mst, mac);
    chk("rdwr_rdata_held", bus.core_rdata, m_rdata);
    chk("rdwr_err", 32'(err), 32'd1);
    chk("rdwr_stall", 32'(st), 32'd2);
    drop_req();
    run_txn(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 0, st, ac);
    model(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 0, mst, mac);
    chk("rdwr_readback", bus.core_rdata, 32'hCAFEF00D);
    drop_req();

    // timeout: memory never ready
    req_hi = 0;
    run_txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 100, st, ac);
    chk("tmo_req_cycles", 32'(req_hi), 32'(TMO));
    chk("tmo_stall", 32'(st), 32'(1 + TMO));
    chk("tmo_rdata", bus.core_rdata, 32'd0);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_req_low", 32'(bus.mem_req), 32'd0);
    m_rdata = 32'd0;
    drop_req();
    run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8, 0, st, ac);
    model(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8, 0, mst, mac);
    chk("err_sticky", 32'(err), 32'd1);
    drop_req();

    // reset in the middle of a data access
    @(negedge clk);
    lat = 100;
    bus.core_read = 1'b1; bus.core_addr = 32'h10; run = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_req_before", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    bus.core_read = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_req", 32'(bus.mem_req), 32'd0);
    chk("midrst_stall", 32'(bus.core_stall), 32'd0);
    chk("midrst_rdata", bus.core_rdata, 32'd0);
    chk("midrst_instr", 32'(bus.core_instr), 32'd0);
    chk("midrst_addr", bus.mem_addr, 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    reset = 1'b0;
    model_reset();

    // run low in DONE holds the stall
    @(negedge clk);
    lat = 0;
    bus.core_read = 1'b1; bus.core_addr = 32'h40; run = 1'b0;
    #1;
    hold = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.core_stall) hold++;
      @(negedge clk);
      #1;
    end
    chk("runlow_stall_cycles", 32'(hold), 32'd8);
    chk("runlow_rdata", bus.core_rdata, ref_mem[8'h40]);
    run = 1'b1;
    #1;
    chk("runlow_release", 32'(bus.core_stall), 32'd0);
    m_rdata = ref_mem[8'h40];
    drop_req();

    // two fetches of the same word
    run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h200, 0, st, ac);
    model(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h200, 0, mst, mac);
    chk("fb1_instr", 32'(bus.core_instr), 32'(ref_mem[8'h80][7:0]));
    chk("fb1_acc", 32'(ac), 32'd1);
    drop_req();
    run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h201, 0, st, ac);
    model(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h201, 0, mst, mac);
    chk("fb2_instr", 32'(bus.core_instr), 32'(ref_mem[8'h80][15:8]));
`ifdef MIC1_ARB_FETCH_BUF_EN
    chk("fb2_acc", 32'(ac), 32'd0);
    chk("fb2_stall", 32'(st), 32'd1);
`else
    chk("fb2_acc", 32'(ac), 32'd1);
    chk("fb2_stall", 32'(st), 32'd2);
`endif
    drop_req();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
